// File: rtl/lsb_evt_pkg.sv
// lsb_evt register map: bit positions, addresses and a popcount helper.
// Shared by the event-capture top and its edge detector.
package lsb_evt_pkg;

    localparam int unsigned PRESS_LSB  = 0;
    localparam int unsigned REL_LSB    = 8;
    localparam int unsigned SWI_LSB    = 16;
    localparam int unsigned CNT_LSB    = 24;
    localparam int unsigned OVF_BIT    = 31;
    localparam int unsigned EN_REL_BIT = 8;
    localparam int unsigned EN_SWI_BIT = 16;

    localparam logic ADDR_STATUS = 1'b0;
    localparam logic ADDR_CTRL   = 1'b1;

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/lsb_evt_edge.sv
// Armed edge detector: prev register plus rise/fall outputs.
// The first clock after reset only loads prev, so held levels never fire.
module lsb_evt_edge #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] cur,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic         armed;
    logic [W-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
            prev  <= '0;
        end else begin
            armed <= 1'b1;
            prev  <= cur;
        end
    end

    assign rise = armed ? (cur & ~prev) : '0;
    assign fall = armed ? (~cur & prev) : '0;

endmodule

// File: rtl/lsb_evt.sv
// Button/switch event capture: sticky W1C flags, saturating press
// counter, overflow bit and a registered maskable interrupt.
module lsb_evt
    import lsb_evt_pkg::*;
#(
    parameter int NBTN = 5,
    parameter int NSWI = 8,
    parameter int CW   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NBTN-1:0] btn,
    input  logic [NSWI-1:0] swi,
    input  logic            addr,
    input  logic            wr,
    input  logic [31:0]     data_in,
    output logic [31:0]     data_out,
    output logic            irq
);

    localparam int SW = CW + 4;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [NBTN-1:0] btn_rise, btn_fall;
    logic [NSWI-1:0] swi_rise, swi_fall;

    logic [NBTN-1:0] press, press_n;
    logic [NBTN-1:0] rel, rel_n;
    logic [NSWI-1:0] swchg, swchg_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            ovf, ovf_n;
    logic [NBTN-1:0] en_press;
    logic            en_rel, en_swi;
    logic            irq_n;

    logic [31:0]     clr_st;
    logic            wr_ctrl;
    logic [NBTN-1:0] clr_press;
    logic [7:0]      rise8;
    logic [CW-1:0]   cnt_base;
    logic [SW-1:0]   sum;
    logic [31:0]     status, ctrl;

    lsb_evt_edge #(.W(NBTN)) u_btn (
        .clk  (clk),
        .rst_n(rst_n),
        .cur  (btn),
        .rise (btn_rise),
        .fall (btn_fall)
    );

    lsb_evt_edge #(.W(NSWI)) u_swi (
        .clk  (clk),
        .rst_n(rst_n),
        .cur  (swi),
        .rise (swi_rise),
        .fall (swi_fall)
    );

    assign clr_st  = (wr && addr == ADDR_STATUS) ? data_in : '0;
    assign wr_ctrl = wr && addr == ADDR_CTRL;

    // Set terms are OR-ed after the clear so a same-cycle event wins.
    always_comb begin
        clr_press = clr_st[PRESS_LSB +: NBTN];
        press_n   = (press & ~clr_press) | btn_rise;
        rel_n     = (rel & ~clr_st[REL_LSB +: NBTN]) | btn_fall;
        swchg_n   = (swchg & ~clr_st[SWI_LSB +: NSWI])
                  | swi_rise | swi_fall;
        ovf_n     = (ovf & ~clr_st[OVF_BIT])
                  | (|(btn_rise & press & ~clr_press));

        rise8             = '0;
        rise8[NBTN-1:0]   = btn_rise;
        cnt_base          = clr_st[CNT_LSB] ? '0 : cnt;
        sum               = SW'(cnt_base) + SW'(popcnt8(rise8));
        cnt_n             = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CW-1:0];

        irq_n = (|(press & en_press))
              | (en_rel & (|rel))
              | (en_swi & (|swchg));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press    <= '0;
            rel      <= '0;
            swchg    <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            en_press <= '0;
            en_rel   <= 1'b0;
            en_swi   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            press <= press_n;
            rel   <= rel_n;
            swchg <= swchg_n;
            cnt   <= cnt_n;
            ovf   <= ovf_n;
            irq   <= irq_n;
            if (wr_ctrl) begin
                en_press <= data_in[NBTN-1:0];
                en_rel   <= data_in[EN_REL_BIT];
                en_swi   <= data_in[EN_SWI_BIT];
            end
        end
    end

    always_comb begin
        status                      = '0;
        status[PRESS_LSB +: NBTN]   = press;
        status[REL_LSB +: NBTN]     = rel;
        status[SWI_LSB +: NSWI]     = swchg;
        status[CNT_LSB +: CW]       = cnt;
        status[OVF_BIT]             = ovf;

        ctrl                        = '0;
        ctrl[NBTN-1:0]              = en_press;
        ctrl[EN_REL_BIT]            = en_rel;
        ctrl[EN_SWI_BIT]            = en_swi;
    end

    assign data_out = (addr == ADDR_STATUS) ? status : ctrl;

    logic unused_clr;
    assign unused_clr = ^clr_st;

endmodule

// File: tb/tb_lsb_evt.sv
// Directed self-checking bench for lsb_evt.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_lsb_evt;

    logic        clk;
    logic        rst_n;
    logic [4:0]  btn;
    logic [7:0]  swi;
    logic        addr;
    logic        wr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    lsb_evt #(.NBTN(5), .NSWI(8), .CW(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .swi     (swi),
        .addr    (addr),
        .wr      (wr),
        .data_in (data_in),
        .data_out(data_out),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic a, input logic [31:0] d);
        addr    = a;
        wr      = 1'b1;
        data_in = d;
        step();
        addr    = 1'b0;
        wr      = 1'b0;
        data_in = '0;
    endtask

    initial begin
        rst_n   = 1'b0;
        btn     = '0;
        swi     = 8'h81;
        addr    = 1'b0;
        wr      = 1'b0;
        data_in = '0;
        #1;
        check("reset_data", data_out, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("arm_data", data_out, 32'h0);
            check("arm_irq", {31'b0, irq}, 32'h0);
        end

        // single press with irq enable
        wr_reg(1'b1, 32'h4);
        btn = 5'b00100;
        step();
        check("press2_status", data_out, 32'h0100_0004);
        check("press2_irq0", {31'b0, irq}, 32'h0);
        step();
        check("press2_irq1", {31'b0, irq}, 32'h1);
        wr_reg(1'b0, 32'h4);
        check("clr2_status", data_out, 32'h0100_0000);
        check("clr2_irq_hold", {31'b0, irq}, 32'h1);
        step();
        check("clr2_irq_drop", {31'b0, irq}, 32'h0);

        // saturation and overflow
        btn = 5'b00000;
        step();
        wr_reg(1'b1, 32'h0);
        wr_reg(1'b0, 32'hFFFF_FFFF);
        check("clear_all", data_out, 32'h0);
        for (int i = 0; i < 20; i++) begin
            btn = 5'b00001;
            step();
            btn = 5'b00000;
            step();
        end
        check("sat_status", data_out, 32'h8F00_0101);
        wr_reg(1'b0, 32'h8100_0000);
        check("cnt_ovf_clr", data_out, 32'h0000_0101);

        // press and clear of the same bit in one cycle
        btn     = 5'b00010;
        addr    = 1'b0;
        wr      = 1'b1;
        data_in = 32'h2;
        step();
        wr      = 1'b0;
        data_in = '0;
        check("set_wins", data_out, 32'h0100_0103);
        btn = 5'b00000;
        step();
        btn     = 5'b00010;
        wr      = 1'b1;
        data_in = 32'h0100_0002;
        step();
        wr      = 1'b0;
        data_in = '0;
        check("cnt_clr_press", data_out, 32'h0100_0303);

        // simultaneous presses add popcount
        btn = 5'b00000;
        step();
        wr_reg(1'b0, 32'hFFFF_FFFF);
        btn = 5'b11111;
        step();
        check("multi_press", data_out, 32'h0500_001F);
        btn = 5'b00000;
        step();
        check("multi_rel", data_out, 32'h0500_1F1F);
        btn = 5'b11111;
        step();
        check("multi_ovf", data_out, 32'h8A00_1F1F);
        btn = 5'b00000;
        step();
        btn = 5'b11111;
        step();
        check("multi_sat", data_out, 32'h8F00_1F1F);

        // switch change irq, release without enable
        btn = 5'b01000;
        wr_reg(1'b1, 32'h0001_0000);
        swi = 8'hA1;
        step();
        wr_reg(1'b0, 32'hFFFF_FFFF);
        swi = 8'h81;
        step();
        check("swchg_status", data_out, 32'h0020_0000);
        swi = 8'hA1;
        step();
        check("swchg_irq", {31'b0, irq}, 32'h1);
        wr_reg(1'b0, 32'hFFFF_FFFF);
        btn = 5'b00000;
        step();
        check("rel3_status", data_out, 32'h0000_0800);
        step();
        step();
        check("rel3_no_irq", {31'b0, irq}, 32'h0);
        wr_reg(1'b1, 32'h0000_0100);
        addr = 1'b1;
        #1;
        check("ctrl_read", data_out, 32'h0000_0100);
        addr = 1'b0;
        step();
        check("rel3_irq", {31'b0, irq}, 32'h1);

        // asynchronous reset mid-operation
        rst_n = 1'b0;
        #1;
        check("async_data", data_out, 32'h0);
        check("async_irq", {31'b0, irq}, 32'h0);
        btn = 5'b00001;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rearm_data", data_out, 32'h0);
        end
        btn = 5'b00000;
        step();
        check("rearm_rel", data_out, 32'h0000_0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
